// File: rtl/tone_seq_pkg.sv
// Shared definitions for the tone sequencer DDS: FSM state encoding,
// waveform select codes and the DAC midscale code.
package tone_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] WAVE_SQUARE = 2'b00;
    localparam logic [1:0] WAVE_SAW    = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;
    localparam logic [1:0] WAVE_SINE   = 2'b11;

    // Midscale at the widest supported DAC; narrower DACs take the top bits.
    localparam int unsigned     MAX_DAC_W     = 12;
    localparam logic [11:0]     MIDSCALE_FULL = 12'h800;

endpackage

// File: rtl/tone_sine_lut.sv
// Quarter-wave sine lookup with a registered output (1 cycle latency).
// Input is the top 6 phase bits: 2 quadrant bits + 4 address bits.
// Only instantiated when TONE_SEQ_SINE_LUT_EN is defined.
module tone_sine_lut
    import tone_seq_pkg::*;
#(
    parameter int DAC_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [5:0]       phase_top,
    output logic [DAC_W-1:0] sample
);

    localparam logic [DAC_W-1:0] MID = MIDSCALE_FULL[MAX_DAC_W-1 -: DAC_W];

    // 127*sin(pi/2 * a/15): a=15 hits the positive peak exactly at phase 1/4.
    function automatic logic [6:0] quarter_amp(input logic [3:0] a);
        logic [6:0] amp;
        case (a)
            4'd0:    amp = 7'd0;
            4'd1:    amp = 7'd13;
            4'd2:    amp = 7'd26;
            4'd3:    amp = 7'd39;
            4'd4:    amp = 7'd52;
            4'd5:    amp = 7'd64;
            4'd6:    amp = 7'd75;
            4'd7:    amp = 7'd85;
            4'd8:    amp = 7'd94;
            4'd9:    amp = 7'd103;
            4'd10:   amp = 7'd110;
            4'd11:   amp = 7'd116;
            4'd12:   amp = 7'd121;
            4'd13:   amp = 7'd124;
            4'd14:   amp = 7'd126;
            4'd15:   amp = 7'd127;
            default: amp = 7'd0;
        endcase
        return amp;
    endfunction

    logic [3:0]       addr_s;
    logic [6:0]       amp_s;
    logic [7:0]       s8_s;
    logic [DAC_W-1:0] out_s;

    // Mirror the address in odd quadrants, negate in the second half-cycle.
    always_comb begin
        addr_s = phase_top[4] ? ~phase_top[3:0] : phase_top[3:0];
        amp_s  = quarter_amp(addr_s);
        if (phase_top[5]) begin
            s8_s = 8'h80 - {1'b0, amp_s};
        end else begin
            s8_s = 8'h80 + {1'b0, amp_s};
        end
    end

    if (DAC_W > 8) begin : g_wide
        assign out_s = {s8_s, {(DAC_W-8){1'b0}}};
    end else if (DAC_W == 8) begin : g_exact
        assign out_s = s8_s;
    end else begin : g_narrow
        assign out_s = s8_s[7 -: DAC_W];
    end

    // Output register gives the LUT its fixed one-cycle latency.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sample <= MID;
        end else begin
            sample <= out_s;
        end
    end

endmodule

// File: rtl/tone_seq_dds.sv
// Tone sequencer: plays a table of (tune, duration) entries through a DDS
// phase accumulator and waveform shaper into a registered DAC sample.
// Optional feature macro: TONE_SEQ_SINE_LUT_EN -- when defined, wave_sel 11
// uses the quarter-wave sine LUT; otherwise wave_sel 11 gives a triangle.
module tone_seq_dds
    import tone_seq_pkg::*;
#(
    parameter int NUM_NOTES = 16,
    parameter int PHASE_W   = 24,
    parameter int DAC_W     = 8,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    input  logic [1:0]                   wave_sel,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_NOTES)-1:0] cfg_addr,
    input  logic [PHASE_W-1:0]           cfg_tune,
    input  logic [15:0]                  cfg_dur,
    output logic [DAC_W-1:0]             dac,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx
);

    localparam int IDX_W = $clog2(NUM_NOTES);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);
    localparam logic [DAC_W-1:0] MID      = MIDSCALE_FULL[MAX_DAC_W-1 -: DAC_W];

    // Square/saw/triangle from the top phase bits. The triangle folds on the
    // MSB and re-uses its top folded bit as LSB so it spans 0..all-ones.
    function automatic logic [DAC_W-1:0] wave_sample(input logic [1:0] sel,
                                                     input logic [DAC_W-1:0] top);
        logic [DAC_W-2:0] fold;
        logic [DAC_W-1:0] smp;
        fold = top[DAC_W-1] ? ~top[DAC_W-2:0] : top[DAC_W-2:0];
        case (sel)
            WAVE_SQUARE: smp = {DAC_W{top[DAC_W-1]}};
            WAVE_SAW:    smp = top;
            WAVE_TRI:    smp = {fold, fold[DAC_W-2]};
            default:     smp = {fold, fold[DAC_W-2]};
        endcase
        return smp;
    endfunction

    logic [PHASE_W-1:0] tune_mem [NUM_NOTES];
    logic [15:0]        dur_mem  [NUM_NOTES];

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   idx_r, idx_n, next_idx_s;
    logic [PHASE_W-1:0] cur_tune_r, phase_r;
    logic [15:0]        cur_dur_r, tick_cnt_r;
    logic [PRE_W-1:0]   presc_r;
    logic               tick_s, play_end_s, gap_end_s, seq_end_s, load_zero_s;
    logic [DAC_W-1:0]   raw_r, sample_s, dac_r;
    logic               v1_r, busy_r, done_r;

    assign tick_s      = (presc_r == PRE_MAX);
    assign play_end_s  = tick_s && (tick_cnt_r == (cur_dur_r - 16'd1));
    assign gap_end_s   = tick_s && (tick_cnt_r == GAP_LAST);
    assign next_idx_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    // Looking ahead at the next entry keeps note_idx from ever showing a
    // zero-duration terminator entry.
    assign seq_end_s   = (idx_r == IDX_LAST) || (dur_mem[next_idx_s] == 16'd0);
    assign load_zero_s = (dur_mem[idx_r] == 16'd0);

    // Table write port; contents are intentionally left out of reset.
    always_ff @(posedge CLOCK_50) begin
        if (cfg_we) begin
            tune_mem[cfg_addr] <= cfg_tune;
            dur_mem[cfg_addr]  <= cfg_dur;
        end
    end

    // Sequencer next state: stop wins over everything except reset.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_n = ST_LOAD;
                    idx_n   = {IDX_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (load_zero_s) begin
                    if (loop) begin
                        state_n = ST_LOAD;
                        idx_n   = {IDX_W{1'b0}};
                    end else begin
                        state_n = ST_DONE;
                    end
                end else begin
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (play_end_s) begin
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_PLAY;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (gap_end_s) begin
                    if (!seq_end_s) begin
                        state_n = ST_LOAD;
                        idx_n   = next_idx_s;
                    end else if (loop) begin
                        state_n = ST_LOAD;
                        idx_n   = {IDX_W{1'b0}};
                    end else begin
                        state_n = ST_DONE;
                    end
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Sequencer state and entry index registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    // Snapshot the entry in LOAD so table writes land at the next LOAD.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cur_tune_r <= {PHASE_W{1'b0}};
            cur_dur_r  <= 16'd0;
        end else if (state_r == ST_LOAD) begin
            cur_tune_r <= tune_mem[idx_r];
            cur_dur_r  <= dur_mem[idx_r];
        end
    end

    // Free-running tick prescaler, re-aligned at every LOAD.
    always_ff @(posedge CLOCK_50) begin
        if (reset || (state_r == ST_LOAD) || tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Whole-tick counter for note duration and inter-note gap.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_cnt_r <= 16'd0;
        end else if ((state_r == ST_PLAY) || (state_r == ST_GAP)) begin
            if (((state_r == ST_PLAY) && play_end_s) || ((state_r == ST_GAP) && gap_end_s)) begin
                tick_cnt_r <= 16'd0;
            end else if (tick_s) begin
                tick_cnt_r <= tick_cnt_r + 16'd1;
            end
        end else begin
            tick_cnt_r <= 16'd0;
        end
    end

    // Phase accumulator: cleared in LOAD, advances by tune every PLAY cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset || (state_r == ST_LOAD)) begin
            phase_r <= {PHASE_W{1'b0}};
        end else if (state_r == ST_PLAY) begin
            phase_r <= phase_r + cur_tune_r;
        end
    end

    // First pipeline stage: shaped sample plus a tone-active flag kept in step.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            raw_r <= MID;
            v1_r  <= 1'b0;
        end else begin
            raw_r <= wave_sample(wave_sel, phase_r[PHASE_W-1 -: DAC_W]);
            v1_r  <= (state_r == ST_PLAY) && (cur_tune_r != {PHASE_W{1'b0}});
        end
    end

`ifdef TONE_SEQ_SINE_LUT_EN
    logic [1:0]       sel_r;
    logic [DAC_W-1:0] sine_s;

    tone_sine_lut #(
        .DAC_W(DAC_W)
    ) u_sine_lut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .phase_top(phase_r[PHASE_W-1 -: 6]),
        .sample   (sine_s)
    );

    // Selection travels beside the LUT output so both paths stay 2 cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sel_r <= WAVE_SQUARE;
        end else begin
            sel_r <= wave_sel;
        end
    end

    assign sample_s = (sel_r == WAVE_SINE) ? sine_s : raw_r;
`else
    assign sample_s = raw_r;
`endif

    // Output stage: midscale whenever the next state is not an active tone,
    // so leaving PLAY silences the DAC on the very next cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dac_r  <= MID;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            dac_r  <= ((state_n == ST_PLAY) && v1_r) ? sample_s : MID;
            busy_r <= (state_n == ST_LOAD) || (state_n == ST_PLAY) || (state_n == ST_GAP);
            done_r <= (state_n == ST_DONE);
        end
    end

    assign dac      = dac_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign note_idx = idx_r;

endmodule

// File: doc/tone_seq_dds.md
TONE_SEQ_DDS -- requirements
Module: tone_seq_dds

Interface
REQ-001 SHALL: parameter NUM_NOTES, 16, sequence table depth (power of 2, 2..256).
REQ-002 SHALL: parameter PHASE_W, 24, phase accumulator width (12..32).
REQ-003 SHALL: parameter DAC_W, 8, output sample width (4..12).
REQ-004 SHALL: parameter TICK_DIV, 50000, CLOCK_50 cycles per duration tick (1 ms).
REQ-005 SHALL: parameter GAP_TICKS, 10, silent ticks between notes.
REQ-006 SHALL: CLOCK_50  in  1  system clock, 50 MHz.
REQ-007 SHALL: reset  in  1  synchronous, active-high.
REQ-008 SHALL: start  in  1  pulse; begin playback at entry 0.
REQ-009 SHALL: stop  in  1  pulse; abort playback.
REQ-010 SHALL: loop  in  1  level; restart at entry 0 instead of finishing.
REQ-011 SHALL: wave_sel  in  2  00 square, 01 saw, 10 triangle, 11 sine.
REQ-012 SHALL: cfg_we / cfg_addr / cfg_tune / cfg_dur  in  1 / log2(NUM_NOTES) / PHASE_W / 16  table write port.
REQ-013 SHALL: dac  out  DAC_W  registered sample; busy  out  1; done  out  1 (1-cycle pulse); note_idx  out  log2(NUM_NOTES).

Function
REQ-014 SHALL: FSM states IDLE, LOAD, PLAY, GAP, DONE.
- IDLE -start-> LOAD; LOAD -> PLAY after 1 cycle.
- PLAY -> GAP after cfg_dur ticks; GAP -> LOAD (next entry) after GAP_TICKS.
REQ-015 SHALL: entry with cfg_dur==0, or wrap from index NUM_NOTES-1, end the sequence: loop=1 -> LOAD entry 0; loop=0 -> DONE (done=1 one cycle) -> IDLE.
REQ-016 SHALL: phase accumulator add cfg_tune modulo 2^PHASE_W every cycle in PLAY; clear to 0 in LOAD.
REQ-017 SHALL: sample from top DAC_W phase bits: square = MSB replicated; saw = bits direct; triangle = fold on MSB, scaled to full range; sine = LUT.
REQ-018 SHALL: dac latency phase-to-output fixed at 2 cycles for every wave_sel.
REQ-019 SHALL: dac = midscale (2^(DAC_W-1)) in IDLE, LOAD, GAP, DONE, and in PLAY when cfg_tune==0.
REQ-020 SHALL: tick prescaler free-running, cleared on LOAD; duration counted in whole ticks.
REQ-021 SHALL: start while busy ignored; stop beats start in the same cycle; stop forces IDLE next cycle, no done pulse.
REQ-022 SHALL: table writes accepted in any state; a write to the entry being played takes effect at that entry's next LOAD.
REQ-023 SHALL: busy = 1 in LOAD, PLAY, GAP; note_idx = current entry.
REQ-024 SHALL: wave_sel changes take effect on the next sample without restarting the phase.

Reset
REQ-025 SHALL: reset -> IDLE, phase 0, prescaler 0, note_idx 0, dac midscale, busy 0, done 0.
REQ-026 SHALL: reset mid-playback take precedence over all inputs; table contents undefined after power-up, unaffected by reset.

Configuration
REQ-027 SHALL: macro TONE_SEQ_SINE_LUT_EN defined -> wave_sel 11 produces quarter-wave sine from LUT.
REQ-028 SHALL: macro undefined -> no LUT instantiated; wave_sel 11 produces triangle; latency still 2 cycles.

Structure
REQ-029 SHALL: shared package tone_seq_pkg holds the FSM state enum, wave_sel encodings, midscale constant.
REQ-030 SHALL: sine LUT as sub-module tone_sine_lut (quarter-wave, registered output, 1-cycle latency).

Verification
REQ-031 SHALL: TICK_DIV=10, entry0 tune=2^20 dur=3, entry1 dur=0, start -> busy 1 for 30 PLAY + 10*GAP_TICKS cycles, then done pulse, dac 0x80.
REQ-032 SHALL: square, tune=2^22, PHASE_W=24 -> dac period 4 cycles, values 0x00,0x00,0xFF,0xFF after 2-cycle latency.
REQ-033 SHALL: loop=1, two entries -> note_idx sequence 0,1,0,1..., done never asserted.
REQ-034 SHALL: stop during PLAY -> next cycle busy 0, dac 0x80, done 0.
REQ-035 SHALL: start and stop same cycle from IDLE -> stays IDLE; start while busy -> note_idx unchanged.
REQ-036 SHALL: wave_sel=11 with and without TONE_SEQ_SINE_LUT_EN -> sine peak 0xFF at phase 1/4 vs triangle values.
